// File: rtl/pipe_pkg.sv
// Shared types and helpers for the memory stage.
// Lane/byte-enable rules live here so the stage and its aligner agree.
package pipe_pkg;

    typedef enum logic [1:0] {
        MEM_B = 2'b00,
        MEM_H = 2'b01,
        MEM_W = 2'b10
    } mem_size_t;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        REQ    = 2'b01,
        WAIT_R = 2'b10
    } lsu_state_t;

    function automatic mem_size_t to_size(input logic [1:0] s);
        mem_size_t r;
        unique case (1'b1)
            s == 2'b00: r = MEM_B;
            s == 2'b01: r = MEM_H;
            default:    r = MEM_W;
        endcase
        return r;
    endfunction

    function automatic logic [3:0] be_of(input mem_size_t s,
                                         input logic [1:0] off);
        logic [3:0] r;
        unique case (1'b1)
            s == MEM_B: r = 4'b0001 << off;
            s == MEM_H: r = 4'b0011 << off;
            default:    r = 4'b1111;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] wdata_rep(input mem_size_t s,
                                              input logic [31:0] d);
        logic [31:0] r;
        unique case (1'b1)
            s == MEM_B: r = {4{d[7:0]}};
            s == MEM_H: r = {2{d[15:0]}};
            default:    r = d;
        endcase
        return r;
    endfunction

    function automatic logic misaligned(input mem_size_t s,
                                        input logic [1:0] off);
        logic r;
        unique case (1'b1)
            s == MEM_H: r = off[0];
            s == MEM_W: r = |off;
            default:    r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/load_align.sv
// Load data aligner: picks the addressed lane and extends it.
// Purely combinational; fed from the latched request offset.
module load_align
    import pipe_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  off,
    input  mem_size_t   size,
    input  logic        is_unsigned,
    output logic [31:0] data
);

    logic [7:0]  b;
    logic [15:0] h;

    always_comb begin
        b    = rdata[8*off +: 8];
        h    = off[1] ? rdata[31:16] : rdata[15:0];
        data = rdata;
        unique case (1'b1)
            size == MEM_B: data = {{24{b[7] & ~is_unsigned}}, b};
            size == MEM_H: data = {{16{h[15] & ~is_unsigned}}, h};
            default:       data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// Memory stage: issues data-bus requests for loads/stores and
// registers the writeback entry behind a valid/ready handshake.
module mem_access
    import pipe_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_is_load,
    input  logic              in_is_store,
    input  logic [1:0]        in_size,
    input  logic              in_unsigned,
    input  logic [XLEN-1:0]   in_addr,
    input  logic [XLEN-1:0]   in_wdata,
    input  logic [REG_AW-1:0] in_rd_ind,
    input  logic [XLEN-1:0]   in_rd_dat,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [REG_AW-1:0] out_rd_ind,
    output logic [XLEN-1:0]   out_rd_dat,
    output logic              out_misalign,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [3:0]        dmem_be,
    output logic [XLEN-1:0]   dmem_addr,
    output logic [XLEN-1:0]   dmem_wdata,
    input  logic              dmem_gnt,
    input  logic              dmem_rvalid,
    input  logic [XLEN-1:0]   dmem_rdata
);

    lsu_state_t        state;
    logic              l_load;
    mem_size_t         l_size;
    logic              l_uns;
    logic [1:0]        l_off;
    logic [REG_AW-1:0] l_rd;

    mem_size_t   sz;
    logic        accept;
    logic        is_mem;
    logic        mis;
    logic        done;
    logic [31:0] ld_dat;

    assign sz       = to_size(in_size);
    assign in_ready = rst_n && (state == IDLE) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign is_mem   = in_is_load || in_is_store;
    assign mis      = misaligned(sz, in_addr[1:0]);

    load_align u_align (
        .rdata       (dmem_rdata),
        .off         (l_off),
        .size        (l_size),
        .is_unsigned (l_uns),
        .data        (ld_dat)
    );

    // rvalid before the grant is not a response to our request
    always_comb begin
        done = 1'b0;
        unique case (state)
            REQ:     done = dmem_gnt && (!l_load || dmem_rvalid);
            WAIT_R:  done = dmem_rvalid;
            default: done = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            l_load       <= 1'b0;
            l_size       <= MEM_B;
            l_uns        <= 1'b0;
            l_off        <= '0;
            l_rd         <= '0;
            out_valid    <= 1'b0;
            out_rd_ind   <= '0;
            out_rd_dat   <= '0;
            out_misalign <= 1'b0;
            dmem_req     <= 1'b0;
            dmem_we      <= 1'b0;
            dmem_be      <= '0;
            dmem_addr    <= '0;
            dmem_wdata   <= '0;
        end else begin
            if (out_valid && out_ready)
                out_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (accept && is_mem && !mis) begin
                        state      <= REQ;
                        l_load     <= in_is_load;
                        l_size     <= sz;
                        l_uns      <= in_unsigned;
                        l_off      <= in_addr[1:0];
                        l_rd       <= in_rd_ind;
                        dmem_req   <= 1'b1;
                        dmem_we    <= !in_is_load;
                        dmem_be    <= be_of(sz, in_addr[1:0]);
                        dmem_addr  <= {in_addr[XLEN-1:2], 2'b00};
                        dmem_wdata <= wdata_rep(sz, in_wdata);
                    end else if (accept) begin
                        out_valid    <= 1'b1;
                        out_misalign <= is_mem;
                        out_rd_ind   <= is_mem ? '0 : in_rd_ind;
                        out_rd_dat   <= is_mem ? '0 : in_rd_dat;
                    end
                end
                REQ: begin
                    if (dmem_gnt) begin
                        dmem_req <= 1'b0;
                        state    <= done ? IDLE : WAIT_R;
                    end
                end
                WAIT_R: begin
                    if (dmem_rvalid)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
            if (done) begin
                out_valid    <= 1'b1;
                out_misalign <= 1'b0;
                out_rd_ind   <= l_load ? l_rd : '0;
                out_rd_dat   <= l_load ? ld_dat : '0;
            end
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// Bench for mem_access: directed vector table, random ops checked
// against an arithmetic model, and handshake/reset sequences.
module tb_mem_access;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_is_load = 1'b0;
    logic        in_is_store = 1'b0;
    logic [1:0]  in_size = 2'b00;
    logic        in_unsigned = 1'b0;
    logic [31:0] in_addr = '0;
    logic [31:0] in_wdata = '0;
    logic [4:0]  in_rd_ind = '0;
    logic [31:0] in_rd_dat = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [4:0]  out_rd_ind;
    logic [31:0] out_rd_dat;
    logic        out_misalign;
    logic        dmem_req;
    logic        dmem_we;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_gnt = 1'b0;
    logic        dmem_rvalid = 1'b0;
    logic [31:0] dmem_rdata = '0;

    always #5 clk = ~clk;

    mem_access dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_is_load   (in_is_load),
        .in_is_store  (in_is_store),
        .in_size      (in_size),
        .in_unsigned  (in_unsigned),
        .in_addr      (in_addr),
        .in_wdata     (in_wdata),
        .in_rd_ind    (in_rd_ind),
        .in_rd_dat    (in_rd_dat),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_rd_ind   (out_rd_ind),
        .out_rd_dat   (out_rd_dat),
        .out_misalign (out_misalign),
        .dmem_req     (dmem_req),
        .dmem_we      (dmem_we),
        .dmem_be      (dmem_be),
        .dmem_addr    (dmem_addr),
        .dmem_wdata   (dmem_wdata),
        .dmem_gnt     (dmem_gnt),
        .dmem_rvalid  (dmem_rvalid),
        .dmem_rdata   (dmem_rdata)
    );

    int checks = 0;
    int failures = 0;

    typedef struct {
        bit          ld;
        bit          st;
        logic [1:0]  size;
        bit          uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [4:0]  rd;
        logic [31:0] rdat;
        int          gdly;
        int          rdly;
        logic [31:0] rdata;
        logic [31:0] e_dat;
        logic [4:0]  e_rd;
        bit          e_mis;
        logic [3:0]  e_be;
        logic [31:0] e_wdata;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic int nbytes(input logic [1:0] s);
        return (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
    endfunction

    function automatic bit m_mis(input logic [1:0] s, input logic [31:0] a);
        return (a % nbytes(s)) != 0;
    endfunction

    function automatic logic [3:0] m_be(input logic [1:0] s,
                                        input logic [31:0] a);
        int n;
        n = nbytes(s);
        return 4'(((1 << n) - 1) << (a % 4));
    endfunction

    function automatic logic [31:0] m_wdata(input logic [1:0] s,
                                            input logic [31:0] d);
        int n;
        n = nbytes(s);
        if (n == 1) return {24'b0, d[7:0]} * 32'h01010101;
        if (n == 2) return {16'b0, d[15:0]} * 32'h00010001;
        return d;
    endfunction

    function automatic logic [31:0] m_load(input logic [31:0] rdata,
                                           input logic [1:0] s, input bit uns,
                                           input logic [31:0] a);
        longint unsigned r;
        longint v;
        longint span;
        int n;
        n = nbytes(s);
        r = rdata;
        span = longint'(1) << (8 * n);
        v = longint'((r >> (8 * (a % 4))) % span);
        if (!uns && n < 4 && v >= span / 2)
            v = v - span;
        return 32'(v);
    endfunction

    task automatic run_op(input vec_t v, input string tag);
        bit mem;
        int n;
        mem = (v.ld || v.st) && !v.e_mis;
        @(negedge clk);
        in_valid    = 1'b1;
        in_is_load  = v.ld;
        in_is_store = v.st;
        in_size     = v.size;
        in_unsigned = v.uns;
        in_addr     = v.addr;
        in_wdata    = v.wdata;
        in_rd_ind   = v.rd;
        in_rd_dat   = v.rdat;
        out_ready   = 1'b1;
        n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, ".in_ready"}, in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        if (mem) begin
            chk({tag, ".req"}, dmem_req, 1);
            chk({tag, ".addr"}, dmem_addr, {v.addr[31:2], 2'b00});
            chk({tag, ".be"}, dmem_be, v.e_be);
            chk({tag, ".we"}, dmem_we, v.ld ? 0 : 1);
            if (!v.ld)
                chk({tag, ".wdata"}, dmem_wdata, v.e_wdata);
            chk({tag, ".busy"}, in_ready, 0);
            for (int i = 0; i < v.gdly; i++) begin
                @(negedge clk);
                chk({tag, ".req_hold"}, dmem_req, 1);
                chk({tag, ".addr_hold"}, dmem_addr, {v.addr[31:2], 2'b00});
                chk({tag, ".be_hold"}, dmem_be, v.e_be);
                if (!v.ld)
                    chk({tag, ".wdata_hold"}, dmem_wdata, v.e_wdata);
            end
            dmem_gnt = 1'b1;
            if (v.ld && v.rdly == 0) begin
                dmem_rvalid = 1'b1;
                dmem_rdata  = v.rdata;
            end
            @(negedge clk);
            dmem_gnt    = 1'b0;
            dmem_rvalid = 1'b0;
            chk({tag, ".req_drop"}, dmem_req, 0);
            if (v.ld && v.rdly > 0) begin
                for (int i = 1; i < v.rdly; i++) begin
                    chk({tag, ".early_valid"}, out_valid, 0);
                    @(negedge clk);
                end
                chk({tag, ".early_valid"}, out_valid, 0);
                dmem_rvalid = 1'b1;
                dmem_rdata  = v.rdata;
                @(negedge clk);
                dmem_rvalid = 1'b0;
            end
        end else begin
            chk({tag, ".no_req"}, dmem_req, 0);
        end
        chk({tag, ".out_valid"}, out_valid, 1);
        chk({tag, ".rd_ind"}, out_rd_ind, v.e_rd);
        chk({tag, ".rd_dat"}, out_rd_dat, v.e_dat);
        chk({tag, ".misalign"}, out_misalign, v.e_mis);
    endtask

    vec_t tbl[12];
    vec_t rv;

    initial begin
        tbl[0]  = '{1,0,2'b10,0,32'h100,0,5'd3,0,0,1,32'hDEADBEEF,
                    32'hDEADBEEF,5'd3,0,4'b1111,0};
        tbl[1]  = '{1,0,2'b00,0,32'h103,0,5'd4,0,0,0,32'h80FF0000,
                    32'hFFFFFF80,5'd4,0,4'b1000,0};
        tbl[2]  = '{1,0,2'b00,1,32'h103,0,5'd4,0,1,0,32'h80FF0000,
                    32'h00000080,5'd4,0,4'b1000,0};
        tbl[3]  = '{1,0,2'b01,0,32'h102,0,5'd6,0,0,1,32'h80010000,
                    32'hFFFF8001,5'd6,0,4'b1100,0};
        tbl[4]  = '{0,1,2'b01,0,32'h202,32'h1234ABCD,5'd9,0,3,0,0,
                    32'h0,5'd0,0,4'b1100,32'hABCDABCD};
        tbl[5]  = '{1,0,2'b10,0,32'h101,0,5'd7,0,0,0,0,
                    32'h0,5'd0,1,4'b0000,0};
        tbl[6]  = '{0,0,2'b00,0,32'h55,0,5'd5,32'h7,0,0,0,
                    32'h7,5'd5,0,4'b0000,0};
        tbl[7]  = '{1,1,2'b10,0,32'h300,32'hFFFF,5'd8,0,1,2,32'h11223344,
                    32'h11223344,5'd8,0,4'b1111,0};
        tbl[8]  = '{0,1,2'b00,0,32'h001,32'h000000A5,5'd2,0,0,0,0,
                    32'h0,5'd0,0,4'b0010,32'hA5A5A5A5};
        tbl[9]  = '{1,0,2'b11,0,32'h010,0,5'd1,0,2,3,32'hCAFEF00D,
                    32'hCAFEF00D,5'd1,0,4'b1111,0};
        tbl[10] = '{0,1,2'b01,0,32'h203,32'h1,5'd3,0,0,0,0,
                    32'h0,5'd0,1,4'b0000,0};
        tbl[11] = '{1,0,2'b01,1,32'h102,0,5'd31,0,0,0,32'h80010000,
                    32'h00008001,5'd31,0,4'b1100,0};

        #2;
        chk("rst.out_valid", out_valid, 0);
        chk("rst.in_ready", in_ready, 0);
        chk("rst.req", dmem_req, 0);
        chk("rst.rd_dat", out_rd_dat, 0);
        chk("rst.be", dmem_be, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++)
            run_op(tbl[i], $sformatf("vec%0d", i));

        // writeback backpressure with a second op waiting
        @(negedge clk);
        in_is_load = 0; in_is_store = 0;
        in_rd_ind = 5'd5; in_rd_dat = 32'd7;
        out_ready = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        chk("bp.valid", out_valid, 1);
        chk("bp.rd", out_rd_ind, 5);
        chk("bp.dat", out_rd_dat, 7);
        chk("bp.in_ready", in_ready, 0);
        in_rd_ind = 5'd9; in_rd_dat = 32'h99;
        @(negedge clk);
        chk("bp.hold_valid", out_valid, 1);
        chk("bp.hold_rd", out_rd_ind, 5);
        chk("bp.hold_dat", out_rd_dat, 7);
        chk("bp.hold_in_ready", in_ready, 0);
        out_ready = 1'b1;
        #1;
        chk("bp.drain_ready", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        chk("bp.next_valid", out_valid, 1);
        chk("bp.next_rd", out_rd_ind, 9);
        chk("bp.next_dat", out_rd_dat, 32'h99);
        @(negedge clk);
        chk("bp.empty", out_valid, 0);

        // reset while waiting for read data
        in_is_load = 1; in_size = 2'b10; in_addr = 32'h400;
        in_rd_ind = 5'd9; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk("rw.req", dmem_req, 1);
        dmem_gnt = 1'b1;
        @(negedge clk);
        dmem_gnt = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rw.req_rst", dmem_req, 0);
        chk("rw.valid_rst", out_valid, 0);
        chk("rw.be_rst", dmem_be, 0);
        chk("rw.addr_rst", dmem_addr, 0);
        chk("rw.in_ready_rst", in_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        dmem_rvalid = 1'b1; dmem_rdata = 32'h12345678;
        @(negedge clk);
        dmem_rvalid = 1'b0;
        chk("rw.late_valid", out_valid, 0);
        chk("rw.late_req", dmem_req, 0);
        @(negedge clk);
        chk("rw.late_valid2", out_valid, 0);
        chk("rw.idle_ready", in_ready, 1);

        // randomized ops against the arithmetic model
        for (int i = 0; i < 60; i++) begin
            int kind;
            kind     = int'($urandom_range(0, 4));
            rv.ld    = (kind == 1) || (kind == 3) || (kind == 4);
            rv.st    = (kind == 2) || (kind == 4);
            rv.size  = 2'($urandom_range(0, 3));
            rv.uns   = 1'($urandom_range(0, 1));
            rv.addr  = $urandom;
            if ($urandom_range(0, 1) == 1)
                rv.addr[1:0] = 2'b00;
            rv.wdata = $urandom;
            rv.rd    = 5'($urandom_range(1, 31));
            rv.rdat  = $urandom;
            rv.gdly  = int'($urandom_range(0, 3));
            rv.rdly  = int'($urandom_range(0, 3));
            rv.rdata = $urandom;
            rv.e_mis = (rv.ld || rv.st) && m_mis(rv.size, rv.addr);
            rv.e_be  = m_be(rv.size, rv.addr);
            rv.e_wdata = m_wdata(rv.size, rv.wdata);
            if (!rv.ld && !rv.st) begin
                rv.e_rd  = rv.rd;
                rv.e_dat = rv.rdat;
            end else if (rv.e_mis || !rv.ld) begin
                rv.e_rd  = 5'd0;
                rv.e_dat = 32'h0;
            end else begin
                rv.e_rd  = rv.rd;
                rv.e_dat = m_load(rv.rdata, rv.size, rv.uns, rv.addr);
            end
            run_op(rv, $sformatf("rnd%0d", i));
        end

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
